piano_key_enc: RTL and testbench



---
 rtl/piano_pkg.sv | 33 +++
 rtl/key_debounce.sv | 56 +++++
 rtl/piano_key_enc.sv | 92 +++++++++
 tb/tb_piano_key_enc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared widths, note codes and octave defaults for the piano front end,
// display stage and tone generator.
package piano_pkg;

  localparam int NOTE_W = 3;
  localparam int OCT_W  = 3;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_DO   = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_FA   = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_SOL  = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_LA   = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_TI   = 3'd7;

  localparam int NUM_KEYS       = 7;
  localparam int DEB_CYCLES_DEF = 20;
  localparam int OCT_RESET_DEF  = 3;
  localparam int OCT_MIN_DEF    = 0;
  localparam int OCT_MAX_DEF    = 6;

  // Lowest-index held key wins; no key held gives NOTE_NONE.
  function automatic logic [NOTE_W-1:0] note_encode(input logic [NUM_KEYS-1:0] keys);
    logic [NOTE_W-1:0] enc;
    enc = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) enc = NOTE_W'(i + 1);
    end
    return enc;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer for one
// raw button; rise pulses on the cycle the stable value goes 0 -> 1.
module key_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int              CW     = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_TC = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle agreeing with the stable value restarts the count, so glitches
  // shorter than DEB_CYCLES never propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_stable <= r_sync2;
        r_rise   <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;

endmodule

// File: rtl/piano_key_enc.sv
// Piano input stage: debounces seven note keys and two octave buttons,
// encodes the winning key and keeps a saturating octave register.
module piano_key_enc
  import piano_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int OCT_RESET  = OCT_RESET_DEF,
  parameter int OCT_MIN    = OCT_MIN_DEF,
  parameter int OCT_MAX    = OCT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        key,
  input  logic              oct_up,
  input  logic              oct_dn,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic              note_valid,
  output logic              note_on
);

  localparam int NUM_IN = NUM_KEYS + 2;

  localparam logic [OCT_W-1:0] OCT_RST_V = OCT_W'(OCT_RESET);
  localparam logic [OCT_W-1:0] OCT_MIN_V = OCT_W'(OCT_MIN);
  localparam logic [OCT_W-1:0] OCT_MAX_V = OCT_W'(OCT_MAX);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_stable;
  logic [NUM_IN-1:0] w_rise;
  logic              w_up;
  logic              w_dn;
  logic [NOTE_W-1:0] w_note_next;
  logic [OCT_W-1:0]  w_oct_next;
  logic              w_unused;

  logic [NOTE_W-1:0] r_note;
  logic [OCT_W-1:0]  r_octave;
  logic              r_note_valid;
  logic              r_note_on;

  // Octave buttons ride above the keys so one generate loop covers all inputs.
  assign w_raw = {oct_dn, oct_up, key};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (w_raw[g]),
      .stable (w_stable[g]),
      .rise   (w_rise[g])
    );
  end

  assign w_up     = w_rise[NUM_KEYS];
  assign w_dn     = w_rise[NUM_KEYS + 1];
  assign w_unused = &{1'b0, w_rise[NUM_KEYS-1:0], w_stable[NUM_IN-1:NUM_KEYS]};

  assign w_note_next = note_encode(w_stable[NUM_KEYS-1:0]);

  always_comb begin
    w_oct_next = r_octave;
    if (w_up && !w_dn && (r_octave < OCT_MAX_V)) begin
      w_oct_next = r_octave + 1'b1;
    end else if (w_dn && !w_up && (r_octave > OCT_MIN_V)) begin
      w_oct_next = r_octave - 1'b1;
    end
  end

  // note_on fires only when the registered note moves to a new nonzero code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note       <= NOTE_NONE;
      r_note_valid <= 1'b0;
      r_note_on    <= 1'b0;
      r_octave     <= OCT_RST_V;
    end else begin
      r_note       <= w_note_next;
      r_note_valid <= (w_note_next != NOTE_NONE);
      r_note_on    <= (w_note_next != NOTE_NONE) && (w_note_next != r_note);
      r_octave     <= w_oct_next;
    end
  end

  assign note       = r_note;
  assign octave     = r_octave;
  assign note_valid = r_note_valid;
  assign note_on    = r_note_on;

endmodule

// File: tb/tb_piano_key_enc.sv
// Scoreboard bench for piano_key_enc: note_on events and octave changes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_piano_key_enc;

  localparam int DEB     = 4;
  localparam int OCT_RST = 3;
  localparam int OCT_LO  = 0;
  localparam int OCT_HI  = 6;

  typedef struct packed {
    logic [2:0] note;
    logic [2:0] oct;
  } on_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] key;
  logic       oct_up;
  logic       oct_dn;
  logic [2:0] note;
  logic [2:0] octave;
  logic       note_valid;
  logic       note_on;

  on_t        q_on[$];
  logic [2:0] q_oct[$];
  logic [2:0] prev_oct;
  int         exp_oct;
  int         n_checks;
  int         n_pass;

  piano_key_enc #(
    .DEB_CYCLES (DEB),
    .OCT_RESET  (OCT_RST),
    .OCT_MIN    (OCT_LO),
    .OCT_MAX    (OCT_HI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .oct_up     (oct_up),
    .oct_dn     (oct_dn),
    .note       (note),
    .octave     (octave),
    .note_valid (note_valid),
    .note_on    (note_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every note_on pulse and every octave change must match the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oct = 3'(OCT_RST);
    end else begin
      if (note_on === 1'b1) begin
        n_checks++;
        if (q_on.size() == 0) begin
          $display("FAIL unexpected_note_on: got note %0d octave %0d, expected no pulse", note, octave);
        end else begin
          on_t e;
          e = q_on.pop_front();
          if (note !== e.note || octave !== e.oct || note_valid !== 1'b1)
            $display("FAIL note_on_event: got note %0d octave %0d valid %0b, expected note %0d octave %0d valid 1",
                     note, octave, note_valid, e.note, e.oct);
          else
            n_pass++;
        end
      end
      if (octave !== prev_oct) begin
        n_checks++;
        if (q_oct.size() == 0) begin
          $display("FAIL unexpected_octave_change: got %0d, previous %0d", octave, prev_oct);
        end else begin
          logic [2:0] eo;
          eo = q_oct.pop_front();
          if (octave !== eo)
            $display("FAIL octave_change: got %0d expected %0d", octave, eo);
          else
            n_pass++;
        end
        prev_oct = octave;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    key    = '0;
    oct_up = 1'b0;
    oct_dn = 1'b0;
    tick(3);
    n_checks++;
    if (note !== 3'd0 || note_valid !== 1'b0 || note_on !== 1'b0 || octave !== 3'(OCT_RST))
      $display("FAIL reset_state: got note %0d valid %0b on %0b octave %0d, expected 0 0 0 %0d",
               note, note_valid, note_on, octave, OCT_RST);
    else
      n_pass++;
    rst_n = 1'b1;
    exp_oct = OCT_RST;
    tick(2);
  endtask

  task automatic test_single_key();
    key = 7'b0000100;
    q_on.push_back('{note: 3'd3, oct: 3'(exp_oct)});
    tick(6);
    n_checks++;
    if (note !== 3'd0) $display("FAIL single_early: got note %0d expected 0", note);
    else n_pass++;
    tick(1);
    n_checks++;
    if (note !== 3'd3 || note_valid !== 1'b1 || note_on !== 1'b1 || octave !== 3'd3)
      $display("FAIL single_latency: got note %0d valid %0b on %0b octave %0d, expected 3 1 1 3",
               note, note_valid, note_on, octave);
    else n_pass++;
    tick(1);
    n_checks++;
    if (note !== 3'd3 || note_on !== 1'b0)
      $display("FAIL single_pulse_width: got note %0d on %0b, expected 3 0", note, note_on);
    else n_pass++;
    key = '0;
    tick(10);
    n_checks++;
    if (note !== 3'd0 || note_valid !== 1'b0)
      $display("FAIL single_release: got note %0d valid %0b, expected 0 0", note, note_valid);
    else n_pass++;
  endtask

  task automatic test_glitch();
    key = 7'b0000010;
    tick(3);
    key = '0;
    tick(12);
    n_checks++;
    if (note !== 3'd0) $display("FAIL glitch_3cyc: got note %0d expected 0", note);
    else n_pass++;
    key = 7'b0000010;
    q_on.push_back('{note: 3'd2, oct: 3'(exp_oct)});
    tick(4);
    key = '0;
    tick(3);
    n_checks++;
    if (note !== 3'd2 || note_valid !== 1'b1)
      $display("FAIL glitch_4cyc: got note %0d valid %0b expected 2 1", note, note_valid);
    else n_pass++;
    tick(10);
    n_checks++;
    if (note !== 3'd0 || note_valid !== 1'b0)
      $display("FAIL glitch_4cyc_release: got note %0d valid %0b expected 0 0", note, note_valid);
    else n_pass++;
  endtask

  task automatic test_priority();
    key = 7'b1000001;
    q_on.push_back('{note: 3'd1, oct: 3'(exp_oct)});
    tick(10);
    n_checks++;
    if (note !== 3'd1) $display("FAIL priority_low_wins: got %0d expected 1", note);
    else n_pass++;
    key = 7'b1000000;
    q_on.push_back('{note: 3'd7, oct: 3'(exp_oct)});
    tick(10);
    n_checks++;
    if (note !== 3'd7) $display("FAIL priority_fallback: got %0d expected 7", note);
    else n_pass++;
    key = '0;
    tick(10);
    n_checks++;
    if (note !== 3'd0 || note_valid !== 1'b0)
      $display("FAIL priority_release_all: got note %0d valid %0b expected 0 0", note, note_valid);
    else n_pass++;
  endtask

  task automatic press(input logic up);
    if (up) begin
      if (exp_oct < OCT_HI) begin exp_oct++; q_oct.push_back(3'(exp_oct)); end
      oct_up = 1'b1;
    end else begin
      if (exp_oct > OCT_LO) begin exp_oct--; q_oct.push_back(3'(exp_oct)); end
      oct_dn = 1'b1;
    end
    tick(8);
    oct_up = 1'b0;
    oct_dn = 1'b0;
    tick(8);
    n_checks++;
    if (octave !== 3'(exp_oct)) $display("FAIL octave_press: got %0d expected %0d", octave, exp_oct);
    else n_pass++;
  endtask

  task automatic test_octave();
    for (int i = 0; i < 5; i++) press(1'b1);
    for (int i = 0; i < 7; i++) press(1'b0);
    exp_oct++;
    q_oct.push_back(3'(exp_oct));
    oct_up = 1'b1;
    tick(50);
    n_checks++;
    if (octave !== 3'(exp_oct)) $display("FAIL octave_hold: got %0d expected %0d", octave, exp_oct);
    else n_pass++;
    oct_up = 1'b0;
    tick(10);
    n_checks++;
    if (octave !== 3'(exp_oct)) $display("FAIL octave_hold_release: got %0d expected %0d", octave, exp_oct);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    oct_up = 1'b1;
    oct_dn = 1'b1;
    tick(8);
    oct_up = 1'b0;
    oct_dn = 1'b0;
    tick(8);
    n_checks++;
    if (octave !== 3'(exp_oct)) $display("FAIL octave_both: got %0d expected %0d", octave, exp_oct);
    else n_pass++;
    key = 7'b0000010;
    q_on.push_back('{note: 3'd2, oct: 3'(exp_oct)});
    tick(8);
    press(1'b1);
    n_checks++;
    if (note !== 3'd2 || note_valid !== 1'b1)
      $display("FAIL note_during_octave: got note %0d valid %0b expected 2 1", note, note_valid);
    else n_pass++;
    key = '0;
    tick(10);
  endtask

  task automatic test_reset_mid();
    while (exp_oct < 5) press(1'b1);
    key = 7'b0010000;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (note !== 3'd0 || octave !== 3'(OCT_RST) || note_valid !== 1'b0)
      $display("FAIL reset_mid_async: got note %0d octave %0d valid %0b expected 0 %0d 0",
               note, octave, note_valid, OCT_RST);
    else n_pass++;
    exp_oct = OCT_RST;
    tick(2);
    rst_n = 1'b1;
    q_on.push_back('{note: 3'd5, oct: 3'(exp_oct)});
    tick(6);
    n_checks++;
    if (note !== 3'd0) $display("FAIL reset_mid_early: got note %0d expected 0", note);
    else n_pass++;
    tick(1);
    n_checks++;
    if (note !== 3'd5 || note_on !== 1'b1)
      $display("FAIL reset_mid_redebounce: got note %0d on %0b expected 5 1", note, note_on);
    else n_pass++;
    key = '0;
    tick(10);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_oct  = OCT_RST;
    prev_oct = 3'(OCT_RST);
    rst_n    = 1'b0;
    key      = '0;
    oct_up   = 1'b0;
    oct_dn   = 1'b0;
    test_reset();
    test_single_key();
    test_glitch();
    test_priority();
    test_octave();
    test_simultaneous();
    test_reset_mid();
    n_checks++;
    if (q_on.size() != 0 || q_oct.size() != 0)
      $display("FAIL scoreboard_drain: got %0d note_on and %0d octave events left, expected 0 0",
               q_on.size(), q_oct.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
